step_sequencer: RTL

Programmable 16-step note sequencer that drives the synthesizer's pitch and gate controls in place of the board switches and buttons. It holds a small pattern memory of note/octave/gate words, steps through it at a programmable tempo, and presents the current step on `sw`/`octave`/`en` so the downstream clock divider and LUT generators play a melody. It sits between the user or CPU write port and the existing `clk_div` / LUT generator datapath in `synth_wrapper`.

---
 rtl/step_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// step_sequencer: programmable note/octave/gate pattern player feeding clk_div and the LUT generators.
// Define STEP_SEQ_LOOP_EN to loop the pattern forever; otherwise it plays once and pulses done.
module step_sequencer #(
  parameter int STEPS = 16,
  parameter int TEMPO_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [13:0]              wr_data,
  input  logic [$clog2(STEPS)-1:0] last_step,
  input  logic [TEMPO_W-1:0]       tempo,
  input  logic [TEMPO_W-1:0]       gate_len,
  output logic [10:0]              sw,
  output logic [1:0]               octave,
  output logic                     en,
  output logic                     busy,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_pulse,
  output logic                     done
);
  localparam int AW = $clog2(STEPS);
`ifdef STEP_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  state_t state;
  logic [13:0] mem [STEPS];
  logic [13:0] rd_data;
  logic [AW-1:0] pf_addr;
  logic [AW-1:0] rd_addr;
  logic [TEMPO_W-1:0] cnt;
  logic [TEMPO_W-1:0] t_m1;
  logic gate;
  logic go;
  logic last_cnt;
  logic finish;
  logic present;
  logic refetch;
  logic rd_en;
  function automatic logic [AW-1:0] nxt_of(input logic [AW-1:0] a, input logic [AW-1:0] l);
    return (a == l) ? '0 : a + 1'b1;
  endfunction
  // rd_data always holds the word for pf_addr, the step presented at the next boundary
  always_comb begin
    t_m1 = (tempo == '0) ? '0 : tempo - 1'b1;
    go = start && !stop;
    last_cnt = cnt >= t_m1;
    finish = !LOOP && state == PLAY && last_cnt && step_idx == last_step;
    present = !stop && !go && (state == LOAD || (state == PLAY && last_cnt && !finish));
    refetch = !stop && !go && state == PLAY && !last_cnt && nxt_of(step_idx, last_step) != pf_addr;
    rd_en = go || present || refetch;
    rd_addr = go ? '0 : present ? nxt_of(pf_addr, last_step) : nxt_of(step_idx, last_step);
  end
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      gate <= 1'b0;
      pf_addr <= '0;
      sw <= '0;
      octave <= '0;
      en <= 1'b0;
      busy <= 1'b0;
      step_idx <= '0;
      step_pulse <= 1'b0;
      done <= 1'b0;
    end else begin
      step_pulse <= present;
      done <= 1'b0;
      if (rd_en) pf_addr <= rd_addr;
      if (stop) begin
        state <= IDLE;
        en <= 1'b0;
        busy <= 1'b0;
      end else if (go) begin
        state <= LOAD;
        en <= 1'b0;
        busy <= 1'b1;
        cnt <= '0;
      end else if (present) begin
        state <= PLAY;
        cnt <= '0;
        {gate, octave, sw} <= rd_data;
        step_idx <= pf_addr;
        en <= rd_data[13] && gate_len != '0;
      end else if (finish) begin
        state <= IDLE;
        en <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end else if (state == PLAY) begin
        cnt <= cnt + 1'b1;
        en <= gate && (cnt + 1'b1 < gate_len);
      end
    end
  end
endmodule
